nfc_atomic_ca_latch: RTL
========================

Name: nfc_atomic_ca_latch

Overview:
- Atomic command generator (ACG) primitive for command/address latch cycles. It is the responder on the ACG bus selected by command bit 6.
- Accepts one CA request from a command-level FSM (reset, read-ID, program, erase, and similar). It serialises 1–5 command or address bytes onto the NAND pins with CE#, CLE, ALE and WE# timing, then signals completion.
- Its ready output drives bit 6 of the shared ACG ready vector. Its last-step output drives bit 6 of the shared ACG last-step vector.

Parameters:
- NumberOfWays, 4: number of NAND ways (CE# lines).
- CESetupCycles, 1: cycles CE# is low before the first WE# fall (minimum 1).
- WELowCycles, 2: WE# low cycles per byte (tWP; minimum 1).
- WEHighCycles, 2: WE# high cycles per byte; DQ is held through this interval (tWH/tDH; minimum 1).
- CEHoldCycles, 1: cycles CE# stays low after the last WE# rise (minimum 1).

Ports:
- iSystemClock  in  1  system clock; all logic on rising edge.
- iReset  in  1  synchronous, active-low reset.
- iACG_Command  in  8  one-hot primitive select; only bit 6 is decoded.
- iACG_CommandOption  in  3  reserved; ignored.
- iACG_TargetWay  in  NumberOfWays  active-low way mask (0 = selected).
- iACG_NumOfData  in  16  number of CA bytes.
- iACG_CASelect  in  1  1 = command bytes (CLE), 0 = address bytes (ALE).
- iACG_CAData  in  40  CA bytes; [39:32] is sent first.
- oACG_Ready  out  1  idle, able to accept a request.
- oACG_LastStep  out  1  one-cycle completion pulse.
- oNAND_CE_n  out  NumberOfWays  chip enables, active low.
- oNAND_CLE  out  1  command latch enable.
- oNAND_ALE  out  1  address latch enable.
- oNAND_WE_n  out  1  write enable, active low.
- oNAND_DQ  out  8  data bus value.
- oNAND_DQOE  out  1  DQ output enable for the pad tristate.

Behaviour:
- All outputs are registered.
- Reset values (iReset = 0 at a rising edge): oACG_Ready = 1, oACG_LastStep = 0, oNAND_CE_n = all 1, oNAND_CLE = 0, oNAND_ALE = 0, oNAND_WE_n = 1, oNAND_DQ = 8'h00, oNAND_DQOE = 0, state = IDLE.
- Reset mid-operation aborts immediately to the reset values. No completion pulse is emitted.
- Acceptance: at an edge where state = IDLE and iACG_Command[6] = 1, the block latches TargetWay, CASelect, CAData and the byte count. Other command bits are don't-care.
  - Byte count = iACG_NumOfData clamped: 0 → 1, values > 5 → 5.
  - oACG_Ready drops to 0 from the next cycle.
  - Command bit 6 asserted while busy is ignored. The request is not queued.
- State machine (state counter counts cycles; transitions on counter expiry):
  - IDLE: Ready = 1, all pins idle. Exits to CE_SETUP on acceptance.
  - CE_SETUP, CESetupCycles cycles: CE_n = latched way mask. CLE = CASelect, ALE = ~CASelect. DQ = current byte. DQOE = 1. WE_n = 1.
  - WE_LOW, WELowCycles cycles: WE_n = 0. Other pins held.
  - WE_HIGH, WEHighCycles cycles: WE_n = 1. DQ/CLE/ALE held.
    - At exit, the byte counter decrements and the shift register shifts left by 8 (the next byte appears on DQ in the following cycle).
    - If bytes remain, go to WE_LOW; otherwise go to CE_HOLD.
  - CE_HOLD, CEHoldCycles cycles: CLE = 0, ALE = 0, DQOE = 0, WE_n = 1, CE_n still asserted.
  - DONE, 1 cycle: CE_n = all 1, oACG_LastStep = 1. Next state is IDLE, where Ready = 1 again.
- Latency from the acceptance edge to the LastStep cycle = CESetupCycles + N·(WELowCycles + WEHighCycles) + CEHoldCycles + 1 cycles.
  - Defaults, N = 1: 7 cycles.
  - Defaults, N = 5: 23 cycles.
- Back-to-back: a request present during the first IDLE cycle after DONE is accepted at that edge (one idle cycle minimum between operations).
- A TargetWay mask of all 1s is still executed: pins toggle and no CE# is asserted. Multiple 0 bits assert multiple CE# lines.
- WE# never glitches. CLE and ALE are never both 1. DQOE = 1 whenever WE_n = 0.

Test Plan:
- Reset command: Command = 8'h40, CASelect = 1, NumOfData = 1, CAData = 40'hFF_00000000, TargetWay = 4'b1110 → CE_n[0] low for 6 cycles, CLE = 1, a single 2-cycle WE# low pulse with DQ = FFh, LastStep pulse 7 cycles after acceptance, Ready = 1 the next cycle.
- 5-byte address: CASelect = 0, NumOfData = 5, CAData = 40'h0102030405 → ALE = 1, five WE# pulses with DQ = 01, 02, 03, 04, 05 in order, LastStep at cycle 23.
- Clamping: NumOfData = 0 → exactly 1 WE# pulse. NumOfData = 16'h0009 → exactly 5 WE# pulses.
- Busy/ignore: Command = 8'h40 held high throughout, plus Command = 8'h08 alone while idle → exactly one operation per IDLE acceptance; 8'h08 causes no pin activity and Ready stays 1.
- Reset mid-op: assert iReset = 0 during the 3rd WE_LOW of a 5-byte operation → next cycle all outputs at reset values, no LastStep pulse. A new request after release completes normally.
- Parameter sweep: WELowCycles = 1, WEHighCycles = 3 → WE# low width 1 cycle, high width 3 cycles, and DQ is stable across each WE# rising edge.

Source files
------------

// File: rtl/nfc_atomic_ca_latch_if.sv
// ACG request bus between a command-level FSM and the
// command/address latch primitive.
interface nfc_atomic_ca_latch_if #(
   parameter int NumberOfWays = 4
) ();

   logic [7:0]              iACG_Command;
   logic [2:0]              iACG_CommandOption;
   logic [NumberOfWays-1:0] iACG_TargetWay;
   logic [15:0]             iACG_NumOfData;
   logic                    iACG_CASelect;
   logic [39:0]             iACG_CAData;
   logic                    oACG_Ready;
   logic                    oACG_LastStep;

   modport master (
      output iACG_Command,
      output iACG_CommandOption,
      output iACG_TargetWay,
      output iACG_NumOfData,
      output iACG_CASelect,
      output iACG_CAData,
      input  oACG_Ready,
      input  oACG_LastStep
   );

   modport slave (
      input  iACG_Command,
      input  iACG_CommandOption,
      input  iACG_TargetWay,
      input  iACG_NumOfData,
      input  iACG_CASelect,
      input  iACG_CAData,
      output oACG_Ready,
      output oACG_LastStep
   );

endinterface

// File: rtl/nfc_atomic_ca_latch.sv
// Atomic command/address latch primitive: serialises 1-5 CA
// bytes onto the NAND pins with CE#/CLE/ALE/WE# timing.
module nfc_atomic_ca_latch #(
   parameter int NumberOfWays = 4,
   parameter int CESetupCycles = 1,
   parameter int WELowCycles = 2,
   parameter int WEHighCycles = 2,
   parameter int CEHoldCycles = 1
) (
   input  logic                    iSystemClock,
   input  logic                    iReset,
   nfc_atomic_ca_latch_if.slave    acg,
   output logic [NumberOfWays-1:0] oNAND_CE_n,
   output logic                    oNAND_CLE,
   output logic                    oNAND_ALE,
   output logic                    oNAND_WE_n,
   output logic [7:0]              oNAND_DQ,
   output logic                    oNAND_DQOE
);

   typedef enum logic [2:0] {
      Idle,
      CeSetup,
      WeLow,
      WeHigh,
      CeHold,
      Done
   } state_t;

   localparam logic [7:0] SetupEnd = 8'(CESetupCycles - 1);
   localparam logic [7:0] LowEnd = 8'(WELowCycles - 1);
   localparam logic [7:0] HighEnd = 8'(WEHighCycles - 1);
   localparam logic [7:0] HoldEnd = 8'(CEHoldCycles - 1);
   localparam logic [NumberOfWays-1:0] AllOff = '1;

   state_t      state;
   logic [7:0]  stepCount;
   logic [2:0]  byteCount;
   logic [39:0] shiftReg;
   logic        stepDone;
   logic        unusedInputs;

   assign stepDone = (stepCount == 8'd0);
   assign unusedInputs = ^{acg.iACG_CommandOption,
                           acg.iACG_Command[7],
                           acg.iACG_Command[5:0]};

   function automatic logic [2:0] clampCount(input logic [15:0] n);
      if (n == 16'd0) return 3'd1;
      if (n > 16'd5) return 3'd5;
      return n[2:0];
   endfunction

   // Sequencer: each state holds for its cycle budget; pins are registered.
   always_ff @(posedge iSystemClock) begin
      if (!iReset) begin
         state <= Idle;
         stepCount <= 8'd0;
         byteCount <= 3'd0;
         shiftReg <= 40'd0;
         acg.oACG_Ready <= 1'b1;
         acg.oACG_LastStep <= 1'b0;
         oNAND_CE_n <= AllOff;
         oNAND_CLE <= 1'b0;
         oNAND_ALE <= 1'b0;
         oNAND_WE_n <= 1'b1;
         oNAND_DQ <= 8'h00;
         oNAND_DQOE <= 1'b0;
      end else begin
         acg.oACG_LastStep <= 1'b0;
         unique case (state)
            Idle: begin
               if (acg.iACG_Command[6]) begin
                  state <= CeSetup;
                  stepCount <= SetupEnd;
                  byteCount <= clampCount(acg.iACG_NumOfData);
                  shiftReg <= acg.iACG_CAData;
                  acg.oACG_Ready <= 1'b0;
                  oNAND_CE_n <= acg.iACG_TargetWay;
                  oNAND_CLE <= acg.iACG_CASelect;
                  oNAND_ALE <= ~acg.iACG_CASelect;
                  oNAND_DQ <= acg.iACG_CAData[39:32];
                  oNAND_DQOE <= 1'b1;
                  oNAND_WE_n <= 1'b1;
               end
            end
            CeSetup: begin
               if (stepDone) begin
                  state <= WeLow;
                  stepCount <= LowEnd;
                  oNAND_WE_n <= 1'b0;
               end else begin
                  stepCount <= stepCount - 8'd1;
               end
            end
            WeLow: begin
               if (stepDone) begin
                  state <= WeHigh;
                  stepCount <= HighEnd;
                  oNAND_WE_n <= 1'b1;
               end else begin
                  stepCount <= stepCount - 8'd1;
               end
            end
            WeHigh: begin
               if (stepDone) begin
                  byteCount <= byteCount - 3'd1;
                  shiftReg <= {shiftReg[31:0], 8'h00};
                  oNAND_DQ <= shiftReg[31:24];
                  if (byteCount == 3'd1) begin
                     state <= CeHold;
                     stepCount <= HoldEnd;
                     oNAND_CLE <= 1'b0;
                     oNAND_ALE <= 1'b0;
                     oNAND_DQOE <= 1'b0;
                  end else begin
                     state <= WeLow;
                     stepCount <= LowEnd;
                     oNAND_WE_n <= 1'b0;
                  end
               end else begin
                  stepCount <= stepCount - 8'd1;
               end
            end
            CeHold: begin
               if (stepDone) begin
                  state <= Done;
                  oNAND_CE_n <= AllOff;
                  oNAND_DQ <= 8'h00;
                  acg.oACG_LastStep <= 1'b1;
               end else begin
                  stepCount <= stepCount - 8'd1;
               end
            end
            Done: begin
               state <= Idle;
               acg.oACG_Ready <= 1'b1;
            end
            default: begin
               state <= Idle;
            end
         endcase
      end
   end

endmodule
